// File: rtl/leds7_cmd_pkg.sv
// Shared definitions for the UART command controller of the 7-segment display.
// Provides the frame sync byte, the command encoding, the parser FSM states
// and the checksum helper used when a frame is completed.
package leds7_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [7:0] {
        CMD_SET_DIGIT = 8'h01,
        CMD_SET_BLANK = 8'h02,
        CMD_CLEAR     = 8'h03
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        GET_CMD,
        GET_ARG,
        GET_CHK
    } state_t;

    // Expected CHK byte of a frame: XOR of SYNC, CMD and ARG.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg);
        return SYNC_BYTE ^ cmd ^ arg;
    endfunction

endpackage

// File: rtl/leds7_frame_timer.sv
// Inter-byte timeout counter for the frame parser.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : reload the counter (byte accepted or parser idle)
//   i_enable       : count down this cycle (a frame is in progress)
//   o_expire       : strobe, CYCLES-1 enabled cycles elapsed since the last clear
// The counter holds the number of cycles left; reload value CYCLES-1 corresponds
// to "zero cycles elapsed", and the strobe fires while it reads zero.
module leds7_frame_timer #(
    parameter int CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int              TW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [TW-1:0]   RELOAD = TW'(CYCLES - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= RELOAD;
        end else if (i_clear) begin
            r_count <= RELOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    // A clear in the same cycle (byte arrival) suppresses the expiry.
    assign o_expire = i_enable && !i_clear && (r_count == '0);

endmodule

// File: rtl/leds7_uart_cmd_ctrl.sv
// Command controller between the UART RX byte stream and the 7-segment driver.
// Parses SYNC/CMD/ARG/CHK frames and keeps the per-digit value and blank bank.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_rx_tdata       : received byte, valid when i_rx_tvalid is high
//   i_rx_tvalid      : one-cycle byte strobe
//   o_digits_data    : 4-bit hex value per digit, digit i in [4i+3:4i]
//   o_digits_blank   : 1 = digit i off
//   o_upd_pulse      : one cycle after a frame executed successfully
//   o_err_pulse      : one cycle after a rejected frame or a timeout
//   o_err_cnt        : saturating error count
module leds7_uart_cmd_ctrl
    import leds7_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 50,
    parameter int DIGITS_NUM = 4,
    parameter int TIMEOUT_US = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_tdata,
    input  logic                    i_rx_tvalid,
    output logic [4*DIGITS_NUM-1:0] o_digits_data,
    output logic [DIGITS_NUM-1:0]   o_digits_blank,
    output logic                    o_upd_pulse,
    output logic                    o_err_pulse,
    output logic [7:0]              o_err_cnt
);

    localparam logic [4:0] DIGITS_LIM = 5'(DIGITS_NUM);

    state_t                    r_state;
    logic [7:0]                r_cmd;
    logic [7:0]                r_arg;
    logic [4*DIGITS_NUM-1:0]   r_digits_data;
    logic [DIGITS_NUM-1:0]     r_digits_blank;
    logic                      r_upd_pulse;
    logic                      r_err_pulse;
    logic [7:0]                r_err_cnt;

    logic                      w_expire;
    logic [3:0]                w_idx;
    logic [3:0]                w_val;
    logic                      w_frame_ok;
    logic [7:0]                w_err_cnt_inc;
    logic [4*DIGITS_NUM-1:0]   w_data_next;
    logic [DIGITS_NUM-1:0]     w_blank_next;

    leds7_frame_timer #(
        .CYCLES (CLK_FREQ * TIMEOUT_US)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_rx_tvalid || (r_state == IDLE)),
        .i_enable (r_state != IDLE),
        .o_expire (w_expire)
    );

    assign w_idx = r_arg[7:4];
    assign w_val = r_arg[3:0];

    // Frame validity is evaluated against the CHK byte currently on the bus.
    assign w_frame_ok = (i_rx_tdata == frame_chk(r_cmd, r_arg))
                     && ((r_cmd == CMD_SET_DIGIT) || (r_cmd == CMD_SET_BLANK) || (r_cmd == CMD_CLEAR))
                     && ((r_cmd != CMD_SET_DIGIT) || ({1'b0, w_idx} < DIGITS_LIM));

    assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    // Candidate register bank contents if the latched command executes.
    generate
        for (genvar gi = 0; gi < DIGITS_NUM; gi++) begin : g_digit
            assign w_data_next[4*gi +: 4] =
                (r_cmd == CMD_CLEAR)                          ? 4'h0 :
                ((r_cmd == CMD_SET_DIGIT) && (w_idx == 4'(gi))) ? w_val :
                                                                r_digits_data[4*gi +: 4];
        end
    endgenerate

    assign w_blank_next = (r_cmd == CMD_CLEAR)     ? '0 :
                          (r_cmd == CMD_SET_BLANK) ? r_arg[DIGITS_NUM-1:0] :
                                                     r_digits_blank;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_cmd          <= 8'h00;
            r_arg          <= 8'h00;
            r_digits_data  <= '0;
            r_digits_blank <= '1;
            r_upd_pulse    <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_err_cnt      <= 8'h00;
        end else begin
            r_upd_pulse <= 1'b0;
            r_err_pulse <= 1'b0;
            // A byte always takes precedence over a simultaneous timeout.
            if (i_rx_tvalid) begin
                case (r_state)
                    IDLE: begin
                        if (i_rx_tdata == SYNC_BYTE) r_state <= GET_CMD;
                    end
                    GET_CMD: begin
                        r_cmd   <= i_rx_tdata;
                        r_state <= GET_ARG;
                    end
                    GET_ARG: begin
                        r_arg   <= i_rx_tdata;
                        r_state <= GET_CHK;
                    end
                    GET_CHK: begin
                        r_state <= IDLE;
                        if (w_frame_ok) begin
                            r_digits_data  <= w_data_next;
                            r_digits_blank <= w_blank_next;
                            r_upd_pulse    <= 1'b1;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_err_cnt   <= w_err_cnt_inc;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (w_expire) begin
                r_state     <= IDLE;
                r_err_pulse <= 1'b1;
                r_err_cnt   <= w_err_cnt_inc;
            end
        end
    end

    assign o_digits_data  = r_digits_data;
    assign o_digits_blank = r_digits_blank;
    assign o_upd_pulse    = r_upd_pulse;
    assign o_err_pulse    = r_err_pulse;
    assign o_err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_leds7_uart_cmd_ctrl.sv
// Scoreboard bench for leds7_uart_cmd_ctrl: the driver pushes the expected
// pulse (kind, cycle, register bank, error count) when it sends the byte that
// should cause it; an independent monitor pops and compares on every pulse.
module tb_leds7_uart_cmd_ctrl;

    localparam int CLK_FREQ   = 50;
    localparam int DIGITS_NUM = 4;
    localparam int TIMEOUT_US = 2;
    localparam int N_TO       = CLK_FREQ * TIMEOUT_US;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic [15:0] digits_data;
    logic [3:0]  digits_blank;
    logic        upd_pulse;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    leds7_uart_cmd_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .DIGITS_NUM (DIGITS_NUM),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_tdata     (rx_tdata),
        .i_rx_tvalid    (rx_tvalid),
        .o_digits_data  (digits_data),
        .o_digits_blank (digits_blank),
        .o_upd_pulse    (upd_pulse),
        .o_err_pulse    (err_pulse),
        .o_err_cnt      (err_cnt)
    );

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [15:0] data;
        logic [3:0]  blank;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   pulses    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (upd_pulse || err_pulse) begin
            pulses = pulses + 1;
            $display("pulse %s cyc=%0d data=%h blank=%b err_cnt=%0d",
                     err_pulse ? "err" : "upd", cyc, digits_data, digits_blank, err_cnt);
            if (sb_q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_pulse actual=upd%0b/err%0b required=none (cycle %0d)",
                         upd_pulse, err_pulse, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_exclusive", {31'b0, upd_pulse & err_pulse}, 32'd0);
                check("pulse_kind_err",  {31'b0, err_pulse}, {31'b0, mon_e.is_err});
                check("pulse_cycle",     cyc, mon_e.cyc);
                check("pulse_data",      {16'b0, digits_data}, {16'b0, mon_e.data});
                check("pulse_blank",     {28'b0, digits_blank}, {28'b0, mon_e.blank});
                check("pulse_err_cnt",   {24'b0, err_cnt}, {24'b0, mon_e.cnt});
            end
        end
    end

    // Called at a negedge; the byte is sampled at the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        @(negedge clk);
        rx_tvalid = 1'b0;
    endtask

    task automatic push_exp(input bit is_err, input int at_cyc, input logic [15:0] d,
                            input logic [3:0] bl, input logic [7:0] c);
        exp_t e;
        e.is_err = is_err;
        e.cyc    = at_cyc;
        e.data   = d;
        e.blank  = bl;
        e.cnt    = c;
        sb_q.push_back(e);
    endtask

    // Full frame; the pulse is due one cycle after the CHK strobe is sampled.
    task automatic frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk,
                         input bit is_err, input logic [15:0] d, input logic [3:0] bl,
                         input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(arg);
        push_exp(is_err, cyc + 1, d, bl, c);
        send_byte(chk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_data",     {16'b0, digits_data}, 32'h0000);
        check("reset_blank",    {28'b0, digits_blank}, 32'hF);
        check("reset_err_cnt",  {24'b0, err_cnt}, 32'd0);
        check("reset_no_pulse", pulses, 0);

        // Valid commands, including the highest legal digit index.
        frame(8'h01, 8'h27, 8'h83, 1'b0, 16'h0700, 4'hF, 8'd0);
        frame(8'h01, 8'h3C, 8'h98, 1'b0, 16'hC700, 4'hF, 8'd0);
        frame(8'h02, 8'h00, 8'hA7, 1'b0, 16'hC700, 4'h0, 8'd0);

        // Bad checksum, index out of range, unknown command.
        frame(8'h01, 8'h27, 8'h84, 1'b1, 16'hC700, 4'h0, 8'd1);
        frame(8'h01, 8'h45, 8'hE1, 1'b1, 16'hC700, 4'h0, 8'd2);
        frame(8'h07, 8'h00, 8'hA2, 1'b1, 16'hC700, 4'h0, 8'd3);

        // SET_BLANK ignores upper ARG bits; garbage in IDLE is silent; CLEAR.
        frame(8'h02, 8'hF5, 8'h52, 1'b0, 16'hC700, 4'h5, 8'd3);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        repeat (4) @(negedge clk);
        check("garbage_err_cnt", {24'b0, err_cnt}, 32'd3);
        frame(8'h03, 8'h00, 8'hA6, 1'b0, 16'h0000, 4'h0, 8'd3);
        repeat (3) @(negedge clk);

        // Stalled frame: timeout N_TO cycles after the last accepted byte.
        send_byte(8'hA5);
        send_byte(8'h01);
        push_exp(1'b1, cyc + N_TO, 16'h0000, 4'h0, 8'd4);
        repeat (N_TO + 5) @(negedge clk);
        frame(8'h01, 8'h0E, 8'hAA, 1'b0, 16'h000E, 4'h0, 8'd4);

        // A byte landing exactly on the expiry cycle keeps the frame alive.
        send_byte(8'hA5);
        repeat (N_TO - 1) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h0A);
        push_exp(1'b0, cyc + 1, 16'h000E, 4'hA, 8'd4);
        send_byte(8'hAD);
        repeat (3) @(negedge clk);

        // Reset between ARG and CHK: frame dropped, CHK ignored, no error.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h27);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h83);
        repeat (5) @(negedge clk);
        check("midreset_data",    {16'b0, digits_data}, 32'h0000);
        check("midreset_blank",   {28'b0, digits_blank}, 32'hF);
        check("midreset_err_cnt", {24'b0, err_cnt}, 32'd0);

        // Error counter saturation at 255.
        for (int i = 0; i < 257; i++) begin
            frame(8'h01, 8'h27, 8'h00, 1'b1, 16'h0000, 4'hF, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
        end
        frame(8'h01, 8'h27, 8'h83, 1'b0, 16'h0700, 4'hF, 8'd255);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leds7_uart_cmd_ctrl.md
Name: leds7_uart_cmd_ctrl

Overview:
- Command controller between the UART RX byte stream (AXIS-like, tdata/tvalid, no tready) and the 7-segment LED driver.
- Parses 4-byte frames (SYNC, CMD, ARG, CHK) and maintains a per-digit value and blank register bank that feeds the LED control block.
- Rejects malformed frames, recovers from stalled frames by timeout, and counts errors.

Parameters:
- CLK_FREQ, 50, clock frequency in MHz
- DIGITS_NUM, 4, number of 7-segment digits (1..8)
- TIMEOUT_US, 1000, maximum gap between bytes of one frame, in microseconds

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_tdata  in  8  received UART byte
- rx_tvalid  in  1  one-cycle strobe; rx_tdata valid
- digits_data  out  4*DIGITS_NUM  hex value per digit; digit i in bits [4i+3:4i]
- digits_blank  out  DIGITS_NUM  1 = digit i off
- upd_pulse  out  1  one-cycle strobe after a successfully executed frame
- err_pulse  out  1  one-cycle strobe on any frame error
- err_cnt  out  8  saturating frame-error count

Behaviour:
- Reset (synchronous, active-high; clock and reset as decided: single clk, synchronous active-high reset):
  - digits_data = 0, digits_blank = all 1, upd_pulse = 0, err_pulse = 0, err_cnt = 0
  - state = IDLE, timer = 0
  - Reset asserted mid-frame discards the frame with no error counted.
- Frame format: SYNC = 0xA5, CMD, ARG, CHK, where CHK = 0xA5 ^ CMD ^ ARG.
- Commands:
  - 0x01 SET_DIGIT: ARG[7:4] = index, ARG[3:0] = value.
  - 0x02 SET_BLANK: digits_blank <= ARG[DIGITS_NUM-1:0]; upper ARG bits ignored.
  - 0x03 CLEAR: all digits_data = 0, digits_blank = 0.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK. All transitions occur only on rx_tvalid, except timeout.
  - IDLE: byte 0xA5 -> GET_CMD; any other byte is discarded silently (no error).
  - GET_CMD -> GET_ARG; GET_ARG -> GET_CHK; CMD and ARG are latched.
  - GET_CHK: compare CHK, then return to IDLE unconditionally.
- Execution timing: the edge sampling a valid CHK also updates the register bank. New values are visible in the following cycle, with upd_pulse = 1 for exactly that cycle (1-cycle latency).
- Errors: err_pulse for one cycle in the same latency slot; registers unchanged. Error causes:
  - checksum mismatch
  - unknown CMD (checked at CHK time)
  - SET_DIGIT index >= DIGITS_NUM
  - timeout
- Timeout:
  - timer clears on each accepted byte and counts while state != IDLE.
  - When timer reaches CLK_FREQ*TIMEOUT_US-1 without a byte: state -> IDLE, err_pulse.
  - If a byte arrives in the same cycle as expiry, the byte wins and no timeout occurs.
- 0xA5 received in GET_CMD/GET_ARG/GET_CHK is treated as data; no resync.
- err_cnt increments on every err_pulse and saturates at 255.
- upd_pulse and err_pulse are never both high.
- Timer width is $clog2(CLK_FREQ*TIMEOUT_US).

Decomposition:
- Package leds7_cmd_pkg:
  - SYNC_BYTE = 8'hA5
  - cmd_t enum {CMD_SET_DIGIT = 8'h01, CMD_SET_BLANK = 8'h02, CMD_CLEAR = 8'h03}
  - state_t enum for the FSM
- Sub-module leds7_frame_timer: parameterised down-counter with clear/enable inputs and an expire strobe output.

Test Plan:
- Reset, then idle for 10 cycles -> digits_data = 0x0000, digits_blank = 4'b1111, err_cnt = 0, no pulses.
- Send A5 01 27 83 -> digit 2 = 7, digits_data = 0x0700, one upd_pulse one cycle after the CHK strobe. Then send A5 02 00 A7 -> digits_blank = 0000.
- Send A5 01 27 84 (bad CHK), then A5 01 45 E1 (index 4), then A5 07 00 A2 (unknown CMD) -> three err_pulse, err_cnt = 3, registers unchanged.
- Send garbage 00 FF 12, then A5 03 00 A6 -> garbage ignored with no error; CLEAR yields digits_data = 0, digits_blank = 0, one upd_pulse.
- With TIMEOUT_US = 2: send A5 01 and stall 100 cycles -> err_pulse at expiry, state IDLE. Then a full valid frame executes normally.
- Assert reset between ARG and CHK of a valid frame -> reset values restored; the following CHK byte is ignored in IDLE and err_cnt stays 0.
